// File: rtl/argmax_classifier.sv
// argmax_classifier: collects N_CLASSES signed scores, buffers them for
// readback and reports the index/value of the largest (lowest index on ties).
module argmax_classifier #(
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              busy,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] class_score,
  output logic              result_valid,
  output logic              done,
  output logic              overflow,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CLASSES - 1);
  localparam logic [IDX_W:0]   NCLS = (IDX_W + 1)'(N_CLASSES);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  count;
  logic              accept;
  logic              last;
  logic [DATA_W-1:0] score_buf [0:(1<<IDX_W)-1];

  // start has priority over a same-cycle sample
  assign accept = (state == S_COLLECT) && in_valid && !start;
  assign last   = (count == LAST);
  assign busy   = (state == S_COLLECT);
  assign done   = (state == S_DONE);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state: start always (re)enters COLLECT; final sample moves to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_COLLECT;
      S_COLLECT: if (start) state_nxt = S_COLLECT;
                 else if (in_valid && last) state_nxt = S_DONE;
      S_DONE:    if (start) state_nxt = S_COLLECT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // sample counter, running max, result pulse and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      class_idx    <= '0;
      class_score  <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= accept && last;
      if (start) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (accept) begin
        count <= count + 1'b1;
        // first sample loads unconditionally; strict > keeps the lower index on ties
        if (count == '0 || $signed(in_data) > $signed(class_score)) begin
          class_idx   <= count;
          class_score <= in_data;
        end
      end else if (state == S_DONE && in_valid) begin
        overflow <= 1'b1;
      end
    end
  end

  // score buffer write; contents need no reset
  always_ff @(posedge clk) begin
    if (accept) score_buf[count] <= in_data;
  end

  // registered readback; out-of-range addresses read as zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    rd_data <= '0;
    else if ({1'b0, rd_addr} < NCLS) rd_data <= score_buf[rd_addr];
    else                          rd_data <= '0;
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: stimulus pushes the expected result
// of each complete run, a monitor pops it whenever result_valid is seen.
module tb_argmax_classifier;
  localparam int N = 10;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  rd_addr = '0;
  logic        busy, result_valid, done, overflow;
  logic [3:0]  class_idx;
  logic [15:0] class_score, rd_data;

  argmax_classifier #(.N_CLASSES(10), .DATA_W(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .busy(busy), .class_idx(class_idx), .class_score(class_score),
    .result_valid(result_valid), .done(done), .overflow(overflow),
    .rd_addr(rd_addr), .rd_data(rd_data));

  always #5 clk = ~clk;

  typedef struct {int idx; int score;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   smp[N];
  int   errors = 0, checks = 0, pushes = 0, pulses = 0;
  bit   prev_rv = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // reference: plain argmax, first occurrence wins
  function automatic exp_t model();
    exp_t r;
    r.idx = 0; r.score = smp[0];
    for (int i = 1; i < N; i++)
      if (smp[i] > r.score) begin r.idx = i; r.score = smp[i]; end
    return r;
  endfunction

  // monitor
  always @(negedge clk) begin
    if (reset) prev_rv = 1'b0;
    else begin
      if (result_valid) begin
        pulses++;
        chk("rv_one_cycle", int'(prev_rv), 0);
        chk("sb_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("sb_idx", int'(class_idx), mon_e.idx);
          chk("sb_score", $signed(class_score), mon_e.score);
          chk("sb_done", int'(done), 1);
        end
      end
      prev_rv = result_valid;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input int d, input int gap);
    in_data = 16'(d); in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic stream(input int gap);
    exp_q.push_back(model()); pushes++;
    for (int i = 0; i < N; i++) send(smp[i], gap);
  endtask

  task automatic check_result(input string tag);
    exp_t e = model();
    int k = 0;
    while (!done && k < 20) begin tick(); k++; end
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_idx"}, int'(class_idx), e.idx);
    chk({tag, "_score"}, $signed(class_score), e.score);
  endtask

  task automatic check_rd(input int addr);
    rd_addr = 4'(addr); tick();
    chk("rd_data", $signed(rd_data), (addr < N) ? smp[addr] : 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx", int'(class_idx), 0);
    chk("rst_score", int'(class_score), 0);
    chk("rst_rv", int'(result_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_rd", int'(rd_data), 0);
    reset = 1'b0;
    tick();

    // ascending, continuous valid
    for (int i = 0; i < N; i++) smp[i] = i;
    do_start();
    chk("asc_busy_collect", int'(busy), 1);
    stream(0);
    chk("asc_rv_latency", int'(result_valid), 1);
    check_result("asc");
    repeat (3) tick();
    chk("asc_done_held", int'(done), 1);
    chk("asc_rv_dropped", int'(result_valid), 0);

    // negatives with gaps, tie keeps lower index
    smp = '{-100, -5, -3, -7, -50, -3, -9, -8, -200, -32768};
    do_start();
    stream(2);
    check_result("neg");

    // extremes
    for (int i = 0; i < N; i++) smp[i] = 32767;
    do_start(); stream(0); check_result("max_eq");
    for (int i = 0; i < N; i++) smp[i] = -32768;
    smp[9] = -32767;
    do_start(); stream(1); check_result("min_last");

    // overflow and readback
    for (int i = 0; i < N; i++) smp[i] = 10 * (i + 1);
    do_start(); stream(0); check_result("ovf_run");
    chk("ovf_before", int'(overflow), 0);
    send(7, 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_idx_kept", int'(class_idx), 9);
    chk("ovf_score_kept", $signed(class_score), 100);
    chk("ovf_done_kept", int'(done), 1);
    check_rd(3);
    check_rd(12);
    check_rd(9);
    do_start();
    chk("ovf_cleared", int'(overflow), 0);
    chk("restart_done_clr", int'(done), 0);

    // restart mid-collection
    for (int i = 0; i < 5; i++) send(1000, 0);
    do_start();
    for (int i = 0; i < N; i++) smp[i] = i;
    stream(0);
    check_result("restart");
    check_rd(0);

    // async reset mid-collection
    do_start();
    for (int i = 0; i < 4; i++) send(500 + i, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_idx", int'(class_idx), 0);
    chk("arst_score", int'(class_score), 0);
    chk("arst_rv", int'(result_valid), 0);
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < N; i++) smp[i] = N - i;
    do_start(); stream(0); check_result("post_rst");

    // randomized runs, some with narrow ranges to force ties
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++)
        smp[i] = (r % 3 == 0) ? int'($urandom_range(0, 6)) - 3
                              : int'($signed(16'($urandom)));
      do_start();
      stream(int'($urandom_range(0, 2)));
      check_result("rand");
      check_rd(int'($urandom_range(0, 15)));
      check_rd(int'($urandom_range(0, 9)));
    end

    repeat (3) tick();
    chk("sb_drain", exp_q.size(), 0);
    chk("pulse_count", pulses, pushes);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Terminal stage of the MNIST inference pipeline. Sits downstream of the second fully-connected layer and consumes its per-neuron output stream (16-bit signed score + valid strobe).
- Counts and buffers N_CLASSES scores, tracks the running signed maximum, and reports the winning class index and score with a done flag.
- Buffered scores can be read back by the top level or a debug path.

Parameters:
- N_CLASSES, 10, number of scores per inference.
- DATA_W, 16, score width, two's-complement signed.
- IDX_W, 4, class index / counter width; must satisfy 2^IDX_W >= N_CLASSES.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- start, input, 1, begins a new collection; sampled on the rising edge.
- in_data, input, DATA_W, signed neuron score.
- in_valid, input, 1, in_data valid this cycle.
- busy, output, 1, high while collecting.
- class_idx, output, IDX_W, index of the maximum score.
- class_score, output, DATA_W, maximum score value.
- result_valid, output, 1, one-cycle pulse when the result is first available.
- done, output, 1, result held valid; stays high until the next start or reset.
- overflow, output, 1, sticky; an extra in_valid arrived after N_CLASSES scores.
- rd_addr, input, IDX_W, score buffer read address.
- rd_data, output, DATA_W, buffered score; registered, 1-cycle latency.

Behaviour:
- Reset (async, active-high): state=IDLE; count=0; class_idx=0, class_score=0, result_valid=0, done=0, busy=0, overflow=0, rd_data=0. Buffer contents are don't-care.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - start=1 -> COLLECT; count=0, overflow=0, done=0.
  - in_valid is ignored.
- COLLECT:
  - busy=1.
  - Each edge with in_valid=1 writes buf[count]=in_data, then count++.
  - Max tracking: if count==0, load the sample unconditionally (class_score=in_data, class_idx=0). Otherwise replace only if in_data > class_score, using a signed compare.
  - Ties keep the lower index.
  - in_valid gaps of any length are allowed; no timeout.
- COLLECT -> DONE: on the edge accepting sample N_CLASSES-1.
  - The compare against the final sample is applied on that same edge.
  - From the following cycle: done=1, busy=0, result_valid=1 for exactly one cycle.
  - class_idx and class_score are stable from then until the next start.
- DONE:
  - in_valid=1 sets overflow=1 (sticky); the data is discarded; the buffer and result are unchanged.
  - start=1 -> COLLECT, with the same clears as from IDLE.
- start during COLLECT: abort and restart. count=0, result registers are reloaded by the next first sample, overflow=0. No result_valid pulse for the aborted run.
- start and in_valid in the same cycle: start wins; that in_valid is not accepted. The first sample is accepted on a later cycle.
- Score buffer:
  - rd_data <= buf[rd_addr] every cycle, independent of state.
  - rd_addr >= N_CLASSES returns 0.
  - A read of an address written on the same edge returns the old value.
- Reset mid-operation: immediate return to the reset values; no result_valid.
- Arithmetic: compare only, no accumulation. All compares are signed DATA_W; no width growth.

Test Plan:
- Ascending scores: start, stream 0..9 with continuous in_valid -> result_valid pulses 1 cycle after sample 9; class_idx=9, class_score=9; done stays 1; busy=0.
- Negatives with gaps: stream -100,-5,-3,-7,-50,-3,-9,-8,-200,-32768 with 2-cycle gaps -> class_idx=2, class_score=-3 (tie with index 5 keeps the lower index).
- All equal and extreme values: all 10 = 32767 -> class_idx=0, class_score=32767. Then start again, stream -32768 x9 followed by -32767 -> class_idx=9.
- Overflow and readback: after a completed run of 10,20,...,100, drive 1 extra in_valid -> overflow=1 and the result is unchanged. rd_addr=3 -> rd_data=40 one cycle later. rd_addr=12 -> rd_data=0. Next start -> overflow=0.
- Restart mid-collection: stream 5 samples of 1000, assert start, then stream 0..9 -> class_idx=9, class_score=9; result_valid pulses exactly once.
- Async reset mid-collection: assert reset between clock edges after 4 samples -> busy, done, class_idx and class_score are 0 immediately. A full run after release operates normally.
